// File: rtl/tbox_share_arbiter_pkg.sv
// Shared types and helpers for the inverse T-box sharing block.
// One physical Td table serves Td0..Td3 through byte rotation.
package tbox_share_arbiter_pkg;

  typedef enum logic [1:0] {
    TD0 = 2'd0,
    TD1 = 2'd1,
    TD2 = 2'd2,
    TD3 = 2'd3
  } td_sel_e;

  localparam int ROM_LATENCY = 1;

  // Rotate right by 8*amt bits: Td_n(x) = ROTR(Td0(x), 8n)
  function automatic logic [31:0] rot_td(
    input logic [31:0] word,
    input logic [1:0]  amt
  );
    logic [31:0] r;
    case (amt)
      2'd1:    r = {word[7:0],  word[31:8]};
      2'd2:    r = {word[15:0], word[31:16]};
      2'd3:    r = {word[23:0], word[31:24]};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tbox_share_arbiter_if.sv
// Request/response bundle between the lanes and the shared T-box.
// master = lane side, slave = arbiter side.
interface tbox_share_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_addr;
  logic [2*NREQ-1:0] req_sel;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [31:0]       rsp_data;

  modport master (
    output req_valid, req_addr, req_sel,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, req_sel,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/tbox_share_arbiter_rr_arbiter.sv
// Round-robin grant over NREQ requesters with a last-winner pointer.
// Search starts one past the last winner and wraps around.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW-1:0] last;

  // Pick the first requester after last, wrapping around
  always_comb begin
    int c;
    c   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      c = (int'(last) + k) % NREQ;
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = IW'(c);
      end
    end
  end

  // Remember the winner; idle cycles leave the pointer alone
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= IW'(NREQ - 1);
    end else if (any) begin
      last <= idx;
    end
  end

endmodule

// File: rtl/tbox_share_arbiter.sv
// Shares one registered Td ROM among NREQ lanes.
// Grant, ROM read, then rotate the word into the requested Td table.
module tbox_share_arbiter
  import tbox_share_arbiter_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int BASE_TABLE = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  tbox_share_arbiter_if.slave  bus,
  output logic [7:0]           rom_a,
  input  logic [31:0]          rom_q,
  output logic                 busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   idx;
  logic            any;
  logic [7:0]      rom_a_q;
  logic [7:0]      win_addr;
  logic [1:0]      win_sel;
  logic            valid1;
  logic [IW-1:0]   tag1;
  td_sel_e         sel1;
  logic [1:0]      amt;
  logic [NREQ-1:0] rsp_valid;
  logic [31:0]     rsp_data;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .clk   (clk),
    .reset (reset),
    .req   (bus.req_valid),
    .gnt   (gnt),
    .idx   (idx),
    .any   (any)
  );

  assign win_addr      = bus.req_addr[8*idx +: 8];
  assign win_sel       = bus.req_sel[2*idx +: 2];
  assign bus.req_ready = gnt;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data;
  assign amt           = sel1 - 2'(BASE_TABLE);

  // ROM address follows the winner, else holds the last one
  always_comb begin
    rom_a = rom_a_q;
    if (any) rom_a = win_addr;
  end

  // Hold register for the ROM address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rom_a_q <= '0;
    else if (any) rom_a_q <= win_addr;
  end

  // Stage 1: capture who was granted and which table they want
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid1 <= 1'b0;
      tag1   <= '0;
      sel1   <= TD0;
    end else begin
      valid1 <= any;
      if (any) begin
        tag1 <= idx;
        sel1 <= td_sel_e'(win_sel);
      end
    end
  end

  // Stage 2: rotate the ROM word and tag it to its requester
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= valid1 ? (NREQ'(1) << tag1) : '0;
      if (valid1) rsp_data <= rot_td(rom_q, amt);
    end
  end

  // Busy while anything is requested or still in flight
  always_comb begin
    busy = valid1 | (|rsp_valid) | (|bus.req_valid);
  end

endmodule

// File: tb/tb_tbox_share_arbiter.sv
// Directed bench for tbox_share_arbiter with a Td2 ROM model.
// Inputs driven #1 after posedge, outputs sampled on negedge.
module tb_tbox_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rom_a;
  logic [31:0] rom_q;
  logic        busy;
  int          nvec = 0;
  int          nmis = 0;

  tbox_share_arbiter_if #(.NREQ(4)) bus ();

  tbox_share_arbiter #(
    .NREQ       (4),
    .BASE_TABLE (2)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus),
    .rom_a (rom_a),
    .rom_q (rom_q),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Td2 entries, Td2(x) = ROTR(Td0(x), 16)
  function automatic logic [31:0] td2(input logic [7:0] a);
    case (a)
      8'h00:   return 32'ha75051f4;
      8'h01:   return 32'h65537e41;
      8'h02:   return 32'ha4c31a17;
      8'h63:   return 32'h00000000;
      default: return {a, ~a, 16'h5a3c};
    endcase
  endfunction

  // Registered ROM, one cycle of read latency
  always_ff @(posedge clk) rom_q <= td2(rom_a);

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_addr = '0;
    bus.req_sel = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nvec++;
    if (bus.req_ready !== 4'b0000) begin
      nmis++;
      $display("FAIL reset_ready: got %b want 0000", bus.req_ready);
    end
    nvec++;
    if (bus.rsp_valid !== 4'b0000) begin
      nmis++;
      $display("FAIL reset_rsp_valid: got %b want 0000", bus.rsp_valid);
    end
    nvec++;
    if (bus.rsp_data !== 32'h0) begin
      nmis++;
      $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data);
    end
    nvec++;
    if (busy !== 1'b0) begin
      nmis++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    nvec++;
    if (rom_a !== 8'h00) begin
      nmis++;
      $display("FAIL reset_rom_a: got %h want 00", rom_a);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_single();
    @(posedge clk);
    #1;
    bus.req_valid = 4'b0001;
    bus.req_addr = 32'h0;
    bus.req_sel = 8'b0000_0010;
    @(negedge clk);
    nvec++;
    if (bus.req_ready !== 4'b0001) begin
      nmis++;
      $display("FAIL single_ready: got %b want 0001", bus.req_ready);
    end
    nvec++;
    if (busy !== 1'b1) begin
      nmis++;
      $display("FAIL single_busy: got %b want 1", busy);
    end
    @(posedge clk);
    #1 bus.req_valid = '0;
    @(negedge clk);
    nvec++;
    if (bus.rsp_valid !== 4'b0000) begin
      nmis++;
      $display("FAIL single_early: got %b want 0000", bus.rsp_valid);
    end
    @(posedge clk);
    @(negedge clk);
    nvec++;
    if (bus.rsp_valid !== 4'b0001) begin
      nmis++;
      $display("FAIL single_rsp_valid: got %b want 0001", bus.rsp_valid);
    end
    nvec++;
    if (bus.rsp_data !== 32'ha75051f4) begin
      nmis++;
      $display("FAIL single_rsp_data: got %h want a75051f4", bus.rsp_data);
    end
  endtask

  task automatic test_rotate();
    logic [1:0]  sv [3];
    logic [31:0] ev [3];
    sv[0] = 2'd3; ev[0] = 32'h4165537e;
    sv[1] = 2'd0; ev[1] = 32'h7e416553;
    sv[2] = 2'd1; ev[2] = 32'h537e4165;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (c < 3) begin
        bus.req_valid = 4'b0010;
        bus.req_addr = 32'h0000_0100;
        bus.req_sel = {4'b0000, sv[c], 2'b00};
      end else begin
        bus.req_valid = '0;
      end
      @(negedge clk);
      if (c < 3) begin
        nvec++;
        if (bus.req_ready !== 4'b0010) begin
          nmis++;
          $display("FAIL rot_ready[%0d]: got %b want 0010", c, bus.req_ready);
        end
      end
      if (c >= 2) begin
        nvec++;
        if (bus.rsp_valid !== 4'b0010) begin
          nmis++;
          $display("FAIL rot_rsp_valid[%0d]: got %b want 0010", c, bus.rsp_valid);
        end
        nvec++;
        if (bus.rsp_data !== ev[c-2]) begin
          nmis++;
          $display("FAIL rot_rsp_data[%0d]: got %h want %h", c, bus.rsp_data, ev[c-2]);
        end
      end
    end
  endtask

  task automatic test_all_four();
    logic [31:0] ev [4];
    logic [3:0]  want;
    ev[0] = 32'ha75051f4;
    ev[1] = 32'h65537e41;
    ev[2] = 32'ha4c31a17;
    ev[3] = 32'h00000000;
    rst = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 4'b1111;
    bus.req_addr = 32'h6302_0100;
    bus.req_sel = 8'b1010_1010;
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
        if (c >= 10) bus.req_valid = '0;
      end
      @(negedge clk);
      want = (c < 10) ? (4'b0001 << (c % 4)) : 4'b0000;
      nvec++;
      if (bus.req_ready !== want) begin
        nmis++;
        $display("FAIL rr_ready[%0d]: got %b want %b", c, bus.req_ready, want);
      end
      if (c >= 2) begin
        want = 4'b0001 << ((c - 2) % 4);
        nvec++;
        if (bus.rsp_valid !== want) begin
          nmis++;
          $display("FAIL rr_rsp_valid[%0d]: got %b want %b", c, bus.rsp_valid, want);
        end
        nvec++;
        if (bus.rsp_data !== ev[(c-2)%4]) begin
          nmis++;
          $display("FAIL rr_rsp_data[%0d]: got %h want %h", c, bus.rsp_data, ev[(c-2)%4]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 7; c++) begin
      @(posedge clk);
      #1;
      if (c < 5) begin
        bus.req_valid = 4'b0100;
        bus.req_addr = 32'h0063_0000;
        bus.req_sel = 8'b0010_0000;
      end else begin
        bus.req_valid = '0;
      end
      @(negedge clk);
      nvec++;
      if (bus.req_ready !== ((c < 5) ? 4'b0100 : 4'b0000)) begin
        nmis++;
        $display("FAIL b2b_ready[%0d]: got %b", c, bus.req_ready);
      end
      nvec++;
      if (bus.rsp_valid !== ((c >= 2) ? 4'b0100 : 4'b0000)) begin
        nmis++;
        $display("FAIL b2b_rsp_valid[%0d]: got %b", c, bus.rsp_valid);
      end
      if (c >= 2) begin
        nvec++;
        if (bus.rsp_data !== 32'h0) begin
          nmis++;
          $display("FAIL b2b_rsp_data[%0d]: got %h want 0", c, bus.rsp_data);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #1;
    bus.req_valid = 4'b0001;
    bus.req_addr = 32'h0000_0100;
    bus.req_sel = 8'b0000_0010;
    @(posedge clk);
    #1;
    bus.req_valid = 4'b0010;
    bus.req_sel = 8'b0000_0000;
    @(negedge clk);
    nvec++;
    if (bus.req_ready !== 4'b0010) begin
      nmis++;
      $display("FAIL mid_ready: got %b want 0010", bus.req_ready);
    end
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    nvec++;
    if (bus.rsp_valid !== 4'b0000) begin
      nmis++;
      $display("FAIL mid_rsp_valid: got %b want 0000", bus.rsp_valid);
    end
    nvec++;
    if (bus.rsp_data !== 32'h0) begin
      nmis++;
      $display("FAIL mid_rsp_data: got %h want 0", bus.rsp_data);
    end
    nvec++;
    if (busy !== 1'b0) begin
      nmis++;
      $display("FAIL mid_busy: got %b want 0", busy);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      nvec++;
      if (bus.rsp_valid !== 4'b0000) begin
        nmis++;
        $display("FAIL mid_stale[%0d]: got %b want 0000", c, bus.rsp_valid);
      end
      @(posedge clk);
    end
    #1;
    bus.req_valid = 4'b1111;
    @(negedge clk);
    nvec++;
    if (bus.req_ready !== 4'b0001) begin
      nmis++;
      $display("FAIL mid_first: got %b want 0001", bus.req_ready);
    end
    @(posedge clk);
    #1 bus.req_valid = '0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_idle();
    logic [3:0] wr;
    logic       wb;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        bus.req_valid = 4'b1000;
        bus.req_addr = 32'h0200_0000;
        bus.req_sel = 8'b1000_0000;
      end else begin
        bus.req_valid = '0;
      end
      @(negedge clk);
      wr = (c == 0) ? 4'b1000 : 4'b0000;
      wb = (c <= 2);
      nvec++;
      if (bus.req_ready !== wr) begin
        nmis++;
        $display("FAIL idle_ready[%0d]: got %b want %b", c, bus.req_ready, wr);
      end
      nvec++;
      if (busy !== wb) begin
        nmis++;
        $display("FAIL idle_busy[%0d]: got %b want %b", c, busy, wb);
      end
      wr = (c == 2) ? 4'b1000 : 4'b0000;
      nvec++;
      if (bus.rsp_valid !== wr) begin
        nmis++;
        $display("FAIL idle_rsp_valid[%0d]: got %b want %b", c, bus.rsp_valid, wr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotate();
    test_all_four();
    test_back_to_back();
    test_reset_mid();
    test_idle();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
